avmm_lvds_bridge_avm_engine: RTL and testbench

- Parametrised successor to the bridge's Avalon-MM master interface. Pops request packets from the link-side request FIFO, executes them on one unified Avalon-MM master (single or burst, read or write), and pushes response packets to the link-side response path.
- Adds configurable data width and a per-transaction watchdog, with abort, drain and pad recovery.
- Appends a status word to every response.

---
 rtl/avmm_lvds_bridge_avm_engine.sv | 181 ++++++++++++++++++
 tb/tb_avmm_lvds_bridge_avm_engine.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/avmm_lvds_bridge_avm_engine.sv
// Avalon-MM master engine: pops link request packets, runs them as single or burst
// transfers, and returns response packets with a trailing status word.
module avmm_lvds_bridge_avm_engine #(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 32,
    parameter int BURSTCNT_W  = 8,
    parameter int TIMEOUT_CYC = 1024,
    parameter int TO_W        = $clog2(TIMEOUT_CYC + 1),
    localparam int BE_W       = DATA_W / 8
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    output logic [ADDR_W-1:0]     m_address_o,
    output logic [BE_W-1:0]       m_byteenable_o,
    output logic [BURSTCNT_W-1:0] m_burstcount_o,
    output logic [DATA_W-1:0]     m_writedata_o,
    output logic                  m_write_o,
    output logic                  m_read_o,
    input  logic [DATA_W-1:0]     m_readdata_i,
    input  logic                  m_waitrequest_i,
    input  logic                  m_readdatavalid_i,
    output logic                  req_rdreq_o,
    input  logic [DATA_W-1:0]     req_q_i,
    input  logic                  req_rdempty_i,
    output logic [DATA_W-1:0]     resp_data_o,
    output logic                  resp_valid_o,
    output logic                  busy_o
);

    // state  | meaning
    // IDLE   | waiting for a command word
    // CMD    | command latched, waiting for the address word
    // ADDR   | address latched, read header emitted
    // WR     | write beats
    // RD     | read command phase
    // RDATA  | collecting read data
    // DRAIN  | discarding payload after a write abort
    // PAD    | zero words after a read abort
    // WHDR   | write header echo
    // STAT   | status word
    typedef enum logic [3:0] {
        S_IDLE, S_CMD, S_ADDR, S_WR, S_RD, S_RDATA, S_DRAIN, S_PAD, S_WHDR, S_STAT
    } state_t;

    state_t                state_q, state_d;
    logic [DATA_W-1:0]     cmd_q;
    logic [ADDR_W-1:0]     addr_q;
    logic [BURSTCNT_W-1:0] bc_q, beats_q, pcnt_q;
    logic [BE_W-1:0]       be_q;
    logic [TO_W-1:0]       wd_q;
    logic                  to_q;
    logic                  resp_valid_d;
    logic [DATA_W-1:0]     resp_data_d, status_w;
    logic                  beat_w, acc_rd, rdv, stall, timeout_hit, step, last;

    assign m_address_o    = addr_q;
    assign m_byteenable_o = be_q;
    assign m_burstcount_o = bc_q;
    assign busy_o         = (state_q != S_IDLE);

    assign beat_w      = m_write_o && !m_waitrequest_i;
    assign acc_rd      = m_read_o && !m_waitrequest_i;
    assign rdv         = (state_q == S_RDATA) && m_readdatavalid_i;
    assign stall       = ((m_write_o || m_read_o) && m_waitrequest_i)
                       || ((state_q == S_RDATA) && !m_readdatavalid_i);
    // the stall that would push the counter to TIMEOUT_CYC is the abort point
    assign timeout_hit = stall && (wd_q == TO_W'(TIMEOUT_CYC - 1));
    assign step        = beat_w || rdv || ((state_q == S_DRAIN) && !req_rdempty_i)
                       || (state_q == S_PAD);
    assign last        = (({1'b0, pcnt_q} + 1'b1) == {1'b0, bc_q});

    always_comb begin
        status_w                   = '0;
        status_w[0]                = to_q;
        status_w[1]                = cmd_q[31];
        status_w[BURSTCNT_W+15:16] = beats_q;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= S_IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (!req_rdempty_i) state_d = S_CMD;
            S_CMD:   if (!req_rdempty_i) state_d = S_ADDR;
            S_ADDR:  state_d = cmd_q[31] ? S_WR : S_RD;
            S_WR:    if (beat_w && last) state_d = S_WHDR;
                     else if (timeout_hit) state_d = S_DRAIN;
            S_RD:    if (acc_rd) state_d = S_RDATA;
                     else if (timeout_hit) state_d = S_PAD;
            S_RDATA: if (rdv && last) state_d = S_STAT;
                     else if (timeout_hit) state_d = S_PAD;
            S_DRAIN: if (!req_rdempty_i && last) state_d = S_WHDR;
            S_PAD:   if (last) state_d = S_STAT;
            S_WHDR:  state_d = S_STAT;
            S_STAT:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        m_write_o     = 1'b0;
        m_read_o      = 1'b0;
        m_writedata_o = '0;
        req_rdreq_o   = 1'b0;
        resp_valid_d  = 1'b0;
        resp_data_d   = '0;
        case (state_q)
            S_IDLE, S_CMD, S_DRAIN: req_rdreq_o = !req_rdempty_i;
            S_ADDR: begin
                resp_valid_d = !cmd_q[31];
                resp_data_d  = cmd_q;
            end
            S_WR: begin
                m_write_o     = !req_rdempty_i;
                m_writedata_o = req_q_i;
                req_rdreq_o   = !req_rdempty_i && !m_waitrequest_i;
            end
            S_RD:    m_read_o = 1'b1;
            S_RDATA: begin
                resp_valid_d = m_readdatavalid_i;
                resp_data_d  = m_readdatavalid_i ? m_readdata_i : '0;
            end
            S_PAD:   resp_valid_d = 1'b1;
            S_WHDR: begin
                resp_valid_d = 1'b1;
                resp_data_d  = cmd_q;
            end
            S_STAT: begin
                resp_valid_d = 1'b1;
                resp_data_d  = status_w;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cmd_q        <= '0;
            addr_q       <= '0;
            bc_q         <= '0;
            be_q         <= '0;
            beats_q      <= '0;
            pcnt_q       <= '0;
            wd_q         <= '0;
            to_q         <= 1'b0;
            resp_valid_o <= 1'b0;
            resp_data_o  <= '0;
        end else begin
            resp_valid_o <= resp_valid_d;
            resp_data_o  <= resp_data_d;
            if (state_q == S_IDLE && !req_rdempty_i) begin
                cmd_q <= req_q_i;
                if (req_q_i[30]) begin
                    bc_q <= (req_q_i[BURSTCNT_W+15:16] == '0) ? BURSTCNT_W'(1)
                                                               : req_q_i[BURSTCNT_W+15:16];
                    be_q <= '1;
                end else begin
                    bc_q <= BURSTCNT_W'(1);
                    be_q <= req_q_i[BE_W-1:0];
                end
            end
            if (state_q == S_CMD && !req_rdempty_i) addr_q <= req_q_i[ADDR_W-1:0];
            if (state_q == S_ADDR) begin
                beats_q <= '0;
                pcnt_q  <= '0;
                to_q    <= 1'b0;
            end else begin
                if (beat_w || rdv) beats_q <= beats_q + 1'b1;
                if (step)          pcnt_q  <= pcnt_q + 1'b1;
                if (timeout_hit)   to_q    <= 1'b1;
            end
            if (state_q == S_ADDR || acc_rd || beat_w || rdv) wd_q <= '0;
            else if (stall)                                   wd_q <= wd_q + 1'b1;
        end
    end

endmodule

// File: tb/tb_avmm_lvds_bridge_avm_engine.sv
// Directed bench for the Avalon-MM master engine: models the show-ahead request FIFO
// and logs Avalon and response traffic, checking against hand-computed values.
module tb_avmm_lvds_bridge_avm_engine;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic [31:0] m_address_o;
    logic [3:0]  m_byteenable_o;
    logic [7:0]  m_burstcount_o;
    logic [31:0] m_writedata_o;
    logic        m_write_o, m_read_o;
    logic [31:0] m_readdata_i = '0;
    logic        m_waitrequest_i = 1'b0;
    logic        m_readdatavalid_i = 1'b0;
    logic        req_rdreq_o;
    logic [31:0] req_q_i = '0;
    logic        req_rdempty_i = 1'b1;
    logic [31:0] resp_data_o;
    logic        resp_valid_o, busy_o;

    avmm_lvds_bridge_avm_engine #(.TIMEOUT_CYC(16)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .m_address_o(m_address_o), .m_byteenable_o(m_byteenable_o),
        .m_burstcount_o(m_burstcount_o), .m_writedata_o(m_writedata_o),
        .m_write_o(m_write_o), .m_read_o(m_read_o), .m_readdata_i(m_readdata_i),
        .m_waitrequest_i(m_waitrequest_i), .m_readdatavalid_i(m_readdatavalid_i),
        .req_rdreq_o(req_rdreq_o), .req_q_i(req_q_i), .req_rdempty_i(req_rdempty_i),
        .resp_data_o(resp_data_o), .resp_valid_o(resp_valid_o), .busy_o(busy_o)
    );

    always #5 clk_i = ~clk_i;

    int          errors = 0;
    int          checks = 0;
    logic [31:0] fifo[$];
    logic [31:0] resp_log[$];
    logic [31:0] wr_log[$];
    logic        hold_empty = 1'b0;
    logic        will_pop = 1'b0;
    int          pop_cnt = 0, wr_hi = 0, rd_hi = 0;
    logic [31:0] last_addr = '0;
    logic [3:0]  last_be = '0;
    logic [7:0]  last_bc = '0;

    task automatic refresh();
        req_rdempty_i = hold_empty || (fifo.size() == 0);
        req_q_i       = (fifo.size() != 0) ? fifo[0] : 32'h0;
    endtask

    always @(negedge clk_i) will_pop = req_rdreq_o && !req_rdempty_i;

    always @(posedge clk_i) begin
        #1;
        if (will_pop && fifo.size() != 0) begin
            void'(fifo.pop_front());
            pop_cnt++;
        end
        refresh();
    end

    always @(negedge clk_i) begin
        if (rst_ni) begin
            if (resp_valid_o) resp_log.push_back(resp_data_o);
            if (m_write_o && !m_waitrequest_i) wr_log.push_back(m_writedata_o);
            if (m_write_o) wr_hi++;
            if (m_read_o) rd_hi++;
            if (m_write_o || m_read_o) begin
                last_addr = m_address_o;
                last_be   = m_byteenable_o;
                last_bc   = m_burstcount_o;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] resp_at(input int i);
        if (i < resp_log.size()) return resp_log[i];
        return 32'hxxxx_xxxx;
    endfunction

    task automatic tick();
        @(posedge clk_i);
        #2;
    endtask

    task automatic clear_logs();
        resp_log.delete();
        wr_log.delete();
        pop_cnt = 0;
        wr_hi   = 0;
        rd_hi   = 0;
    endtask

    task automatic push(input logic [31:0] w);
        fifo.push_back(w);
        refresh();
    endtask

    task automatic run_to_idle(input string tag, input int budget);
        int n = 0;
        do begin
            tick();
            n++;
        end while (busy_o && n < budget);
        check(tag, 32'(busy_o), 32'h0);
        repeat (2) tick();
    endtask

    task automatic wait_read(input string tag);
        for (int n = 0; n < 10 && !m_read_o; n++) tick();
        check(tag, 32'(m_read_o), 32'h1);
    endtask

    initial begin
        logic [31:0] rd_data[4];
        logic [5:0]  pat;
        int          k, e_cnt, w_cnt;

        repeat (2) tick();
        check("rst_write", 32'(m_write_o), 0);
        check("rst_read", 32'(m_read_o), 0);
        check("rst_rdreq", 32'(req_rdreq_o), 0);
        check("rst_valid", 32'(resp_valid_o), 0);
        check("rst_busy", 32'(busy_o), 0);
        check("rst_data", resp_data_o, 0);
        rst_ni = 1'b1;
        tick();

        // non-burst write
        clear_logs();
        push(32'h8000_0003); push(32'h0000_0100); push(32'hA5A5_1234);
        run_to_idle("t1_idle", 30);
        check("t1_beats", wr_log.size(), 1);
        check("t1_wdata", wr_log.size() ? wr_log[0] : 'x, 32'hA5A5_1234);
        check("t1_be", 32'(last_be), 32'h3);
        check("t1_bc", 32'(last_bc), 32'h1);
        check("t1_addr", last_addr, 32'h100);
        check("t1_nresp", resp_log.size(), 2);
        check("t1_hdr", resp_at(0), 32'h8000_0003);
        check("t1_stat", resp_at(1), 32'h0001_0002);

        // burst read, gapped readdatavalid
        clear_logs();
        rd_data = '{32'h1111_0001, 32'h2222_0002, 32'h3333_0003, 32'h4444_0004};
        push(32'h4004_0000); push(32'h0000_0200);
        wait_read("t2_start");
        tick();
        pat = 6'b101101;
        k = 0;
        for (int i = 0; i < 6; i++) begin
            m_readdatavalid_i = pat[5-i];
            m_readdata_i      = pat[5-i] ? rd_data[k] : 32'h0;
            if (pat[5-i]) k++;
            tick();
        end
        m_readdatavalid_i = 1'b0;
        run_to_idle("t2_idle", 10);
        check("t2_rdcyc", rd_hi, 1);
        check("t2_bc", 32'(last_bc), 32'h4);
        check("t2_be", 32'(last_be), 32'hF);
        check("t2_addr", last_addr, 32'h200);
        check("t2_nresp", resp_log.size(), 6);
        check("t2_hdr", resp_at(0), 32'h4004_0000);
        for (int i = 0; i < 4; i++) check("t2_data", resp_at(i + 1), rd_data[i]);
        check("t2_stat", resp_at(5), 32'h0004_0000);

        // burst write with FIFO underrun and waitrequest stalls
        clear_logs();
        push(32'hC008_0000); push(32'h0000_0300);
        for (int i = 0; i < 8; i++) push(32'hB000_0000 + 32'(i));
        e_cnt = 0;
        w_cnt = 0;
        for (int n = 0; n < 120; n++) begin
            tick();
            if (n > 0 && !busy_o) break;
            hold_empty      = (wr_log.size() == 2 && e_cnt < 3);
            if (hold_empty) e_cnt++;
            m_waitrequest_i = (wr_log.size() == 4 && w_cnt < 5);
            if (m_waitrequest_i) w_cnt++;
            refresh();
        end
        hold_empty      = 1'b0;
        m_waitrequest_i = 1'b0;
        refresh();
        check("t3_idle", 32'(busy_o), 0);
        repeat (2) tick();
        check("t3_stalls", 32'(e_cnt + w_cnt), 8);
        check("t3_beats", wr_log.size(), 8);
        for (int i = 0; i < 8; i++)
            check("t3_wdata", i < wr_log.size() ? wr_log[i] : 'x, 32'hB000_0000 + 32'(i));
        check("t3_pops", pop_cnt, 10);
        check("t3_hdr", resp_at(0), 32'hC008_0000);
        check("t3_stat", resp_at(1), 32'h0008_0002);

        // write timeout with waitrequest stuck
        clear_logs();
        m_waitrequest_i = 1'b1;
        push(32'hC004_0000); push(32'h0000_0400);
        for (int i = 0; i < 4; i++) push(32'hC000_0000 + 32'(i));
        run_to_idle("t4_idle", 60);
        m_waitrequest_i = 1'b0;
        check("t4_wrcyc", wr_hi, 16);
        check("t4_beats", wr_log.size(), 0);
        check("t4_fifo", fifo.size(), 0);
        check("t4_pops", pop_cnt, 6);
        check("t4_nresp", resp_log.size(), 2);
        check("t4_hdr", resp_at(0), 32'hC004_0000);
        check("t4_stat", resp_at(1), 32'h0000_0003);

        // read timeout after two beats, then a late readdatavalid
        clear_logs();
        push(32'h4004_0000); push(32'h0000_0500);
        wait_read("t5_start");
        tick();
        m_readdatavalid_i = 1'b1;
        m_readdata_i = 32'h5555_0000; tick();
        m_readdata_i = 32'h5555_0001; tick();
        m_readdatavalid_i = 1'b0;
        repeat (16) tick();
        m_readdatavalid_i = 1'b1;
        m_readdata_i = 32'hDEAD_BEEF;
        repeat (3) tick();
        m_readdatavalid_i = 1'b0;
        run_to_idle("t5_idle", 10);
        check("t5_nresp", resp_log.size(), 6);
        check("t5_hdr", resp_at(0), 32'h4004_0000);
        check("t5_d0", resp_at(1), 32'h5555_0000);
        check("t5_d1", resp_at(2), 32'h5555_0001);
        check("t5_pad0", resp_at(3), 32'h0);
        check("t5_pad1", resp_at(4), 32'h0);
        check("t5_stat", resp_at(5), 32'h0002_0001);

        // reset during RDATA, then a normal single read
        clear_logs();
        push(32'h4002_0000); push(32'h0000_0600);
        wait_read("t6_start");
        tick();
        m_readdatavalid_i = 1'b1;
        m_readdata_i = 32'h6666_0006; tick();
        m_readdatavalid_i = 1'b0;
        check("t6_pre_busy", 32'(busy_o), 1);
        rst_ni = 1'b0;
        #1;
        check("t6_busy", 32'(busy_o), 0);
        check("t6_valid", 32'(resp_valid_o), 0);
        check("t6_data", resp_data_o, 0);
        check("t6_read", 32'(m_read_o), 0);
        check("t6_write", 32'(m_write_o), 0);
        check("t6_rdreq", 32'(req_rdreq_o), 0);
        check("t6_addr", m_address_o, 0);
        check("t6_bc", 32'(m_burstcount_o), 0);
        check("t6_be", 32'(m_byteenable_o), 0);
        repeat (2) tick();
        rst_ni = 1'b1;
        tick();
        clear_logs();
        push(32'h0000_000C); push(32'h0000_0700);
        wait_read("t6b_start");
        tick();
        m_readdatavalid_i = 1'b1;
        m_readdata_i = 32'h7777_0007; tick();
        m_readdatavalid_i = 1'b0;
        run_to_idle("t6b_idle", 10);
        check("t6b_be", 32'(last_be), 32'hC);
        check("t6b_bc", 32'(last_bc), 32'h1);
        check("t6b_addr", last_addr, 32'h700);
        check("t6b_nresp", resp_log.size(), 3);
        check("t6b_hdr", resp_at(0), 32'h0000_000C);
        check("t6b_data", resp_at(1), 32'h7777_0007);
        check("t6b_stat", resp_at(2), 32'h0001_0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
